// File: rtl/video_control_sequencer.sv
// video_control_sequencer
//   Serialises formatter control ops from two requesters: CPU register
//   writes and the palette loader. Each op is held on control_op and
//   control_data for HOLD_CYCLES cycles, so the formatter's 2-flop control
//   synchroniser can capture it. A NOP gap of GAP_CYCLES cycles follows.
//   Requesters are arbitrated round-robin. An OP_VSYNC can optionally be
//   appended after mode-changing CPU ops.
//
// Ports
//   m_axis_vid_aclk  clock
//   aresetn          synchronous active-low reset
//   cpu_valid/ready  CPU op handshake; payload cpu_op[7:0], cpu_data[31:0]
//   pal_valid/ready  palette handshake; payload pal_index[7:0], pal_rgb[23:0]
//   auto_vsync_en    append OP_VSYNC after CPU ops 1, 2 and 4
//   control_op       registered op to the formatter (0 = NOP)
//   control_data     registered payload to the formatter
//   busy             high whenever the sequencer is not idle
//   ops_issued       wrapping count of ops driven, including auto-VSYNC
module video_control_sequencer #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic        m_axis_vid_aclk,
  input  logic        aresetn,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic [7:0]  cpu_op,
  input  logic [31:0] cpu_data,
  input  logic        pal_valid,
  output logic        pal_ready,
  input  logic [7:0]  pal_index,
  input  logic [23:0] pal_rgb,
  input  logic        auto_vsync_en,
  output logic [7:0]  control_op,
  output logic [31:0] control_data,
  output logic        busy,
  output logic [15:0] ops_issued
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_GAP,
    ST_VHOLD,
    ST_VGAP
  } state_t;

  typedef enum logic {
    SRC_CPU,
    SRC_PAL
  } src_t;

  localparam logic [7:0] OP_COLORMODE  = 8'd1;
  localparam logic [7:0] OP_DIMENSIONS = 8'd2;
  localparam logic [7:0] OP_PALETTE    = 8'd3;
  localparam logic [7:0] OP_SCALE      = 8'd4;
  localparam logic [7:0] OP_VSYNC      = 8'd5;

  localparam logic [3:0] HOLD_RELOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] GAP_RELOAD  = 4'(GAP_CYCLES - 1);

  state_t      state;
  src_t        last_grant;
  logic [3:0]  cnt;
  logic        vsync_pending;
  logic        cpu_grant;
  logic        pal_grant;
  logic        cpu_mode_op;

  // Grants are gated by aresetn so that a requester never sees a
  // handshake while the accept is being discarded by reset.
  always_comb begin
    cpu_grant = 1'b0;
    pal_grant = 1'b0;
    if (aresetn && (state == ST_IDLE)) begin
      if (cpu_valid && (!pal_valid || (last_grant == SRC_PAL))) begin
        cpu_grant = 1'b1;
      end else if (pal_valid) begin
        pal_grant = 1'b1;
      end
    end
  end

  assign cpu_ready   = cpu_grant;
  assign pal_ready   = pal_grant;
  assign busy        = (state != ST_IDLE);
  assign cpu_mode_op = (cpu_op == OP_COLORMODE) || (cpu_op == OP_DIMENSIONS) ||
                       (cpu_op == OP_SCALE);

  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      last_grant    <= SRC_PAL;
      cnt           <= '0;
      vsync_pending <= 1'b0;
      control_op    <= '0;
      control_data  <= '0;
      ops_issued    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_grant) begin
            state         <= ST_HOLD;
            cnt           <= HOLD_RELOAD;
            control_op    <= cpu_op;
            control_data  <= cpu_data;
            last_grant    <= SRC_CPU;
            vsync_pending <= auto_vsync_en && cpu_mode_op;
            ops_issued    <= ops_issued + 16'd1;
          end else if (pal_grant) begin
            state         <= ST_HOLD;
            cnt           <= HOLD_RELOAD;
            control_op    <= OP_PALETTE;
            control_data  <= {pal_index, pal_rgb};
            last_grant    <= SRC_PAL;
            vsync_pending <= 1'b0;
            ops_issued    <= ops_issued + 16'd1;
          end
        end

        ST_HOLD: begin
          if (cnt == 4'd0) begin
            state      <= ST_GAP;
            cnt        <= GAP_RELOAD;
            control_op <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        ST_GAP: begin
          if (cnt == 4'd0) begin
            if (vsync_pending) begin
              state         <= ST_VHOLD;
              cnt           <= HOLD_RELOAD;
              control_op    <= OP_VSYNC;
              control_data  <= '0;
              vsync_pending <= 1'b0;
              ops_issued    <= ops_issued + 16'd1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        ST_VHOLD: begin
          if (cnt == 4'd0) begin
            state      <= ST_VGAP;
            cnt        <= GAP_RELOAD;
            control_op <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        ST_VGAP: begin
          if (cnt == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        default: begin
          state      <= ST_IDLE;
          cnt        <= '0;
          control_op <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_control_sequencer.sv
// tb_video_control_sequencer
//   Directed bench for video_control_sequencer with HOLD_CYCLES=4 and
//   GAP_CYCLES=4. Inputs are driven 2 time units after the rising edge, and
//   outputs are sampled there as well.
module tb_video_control_sequencer;

  logic        m_axis_vid_aclk = 1'b0;
  logic        aresetn         = 1'b0;
  logic        cpu_valid       = 1'b0;
  logic        cpu_ready;
  logic [7:0]  cpu_op          = '0;
  logic [31:0] cpu_data        = '0;
  logic        pal_valid       = 1'b0;
  logic        pal_ready;
  logic [7:0]  pal_index       = '0;
  logic [23:0] pal_rgb         = '0;
  logic        auto_vsync_en   = 1'b0;
  logic [7:0]  control_op;
  logic [31:0] control_data;
  logic        busy;
  logic [15:0] ops_issued;

  int checks = 0;
  int fails  = 0;

  video_control_sequencer #(
    .HOLD_CYCLES(4),
    .GAP_CYCLES (4)
  ) dut (
    .m_axis_vid_aclk(m_axis_vid_aclk),
    .aresetn        (aresetn),
    .cpu_valid      (cpu_valid),
    .cpu_ready      (cpu_ready),
    .cpu_op         (cpu_op),
    .cpu_data       (cpu_data),
    .pal_valid      (pal_valid),
    .pal_ready      (pal_ready),
    .pal_index      (pal_index),
    .pal_rgb        (pal_rgb),
    .auto_vsync_en  (auto_vsync_en),
    .control_op     (control_op),
    .control_data   (control_data),
    .busy           (busy),
    .ops_issued     (ops_issued)
  );

  always #5 m_axis_vid_aclk = ~m_axis_vid_aclk;

  task automatic tick();
    @(posedge m_axis_vid_aclk);
    #2;
  endtask

  task automatic test_reset();
    aresetn   = 1'b0;
    cpu_valid = 1'b1;
    pal_valid = 1'b1;
    tick();
    tick();
    checks++; if (control_op !== 8'h00) begin fails++; $display("FAIL reset_op: got %h want 00", control_op); end
    checks++; if (control_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", control_data); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ops_issued !== 16'h0) begin fails++; $display("FAIL reset_ops: got %h want 0", ops_issued); end
    checks++; if ({cpu_ready, pal_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", {cpu_ready, pal_ready}); end
    cpu_valid = 1'b0;
    pal_valid = 1'b0;
    aresetn   = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] exp_op;
    cpu_op        = 8'd2;
    cpu_data      = 32'h02400280;
    auto_vsync_en = 1'b0;
    cpu_valid     = 1'b1;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b want 1", cpu_ready); end
    tick();
    cpu_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_op = (i < 4) ? 8'd2 : 8'd0;
      checks++; if (control_op !== exp_op) begin fails++; $display("FAIL single_op[%0d]: got %h want %h", i, control_op, exp_op); end
      checks++; if (control_data !== 32'h02400280) begin fails++; $display("FAIL single_data[%0d]: got %h want 02400280", i, control_data); end
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy[%0d]: got %b want 1", i, busy); end
      tick();
    end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle: got %b want 0", busy); end
    checks++; if (ops_issued !== 16'd1) begin fails++; $display("FAIL single_ops: got %0d want 1", ops_issued); end
  endtask

  task automatic test_vsync();
    logic [7:0]  exp_op;
    logic [31:0] exp_data;
    cpu_op        = 8'd2;
    cpu_data      = 32'h02400280;
    auto_vsync_en = 1'b1;
    cpu_valid     = 1'b1;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin fails++; $display("FAIL vsync_ready: got %b want 1", cpu_ready); end
    tick();
    // Changing the enable after accept must not cancel the pending VSYNC.
    auto_vsync_en = 1'b0;
    cpu_op        = 8'd7;
    cpu_data      = 32'h77770007;
    for (int i = 0; i < 16; i++) begin
      exp_op   = (i < 4) ? 8'd2 : (i < 8) ? 8'd0 : (i < 12) ? 8'd5 : 8'd0;
      exp_data = (i < 8) ? 32'h02400280 : 32'h0;
      checks++; if (control_op !== exp_op) begin fails++; $display("FAIL vsync_op[%0d]: got %h want %h", i, control_op, exp_op); end
      checks++; if (control_data !== exp_data) begin fails++; $display("FAIL vsync_data[%0d]: got %h want %h", i, control_data, exp_data); end
      checks++; if (cpu_ready !== 1'b0) begin fails++; $display("FAIL vsync_busy_ready[%0d]: got %b want 0", i, cpu_ready); end
      tick();
    end
    checks++; if (cpu_ready !== 1'b1) begin fails++; $display("FAIL vsync_next_ready: got %b want 1", cpu_ready); end
    checks++; if (ops_issued !== 16'd3) begin fails++; $display("FAIL vsync_ops: got %0d want 3", ops_issued); end
    tick();
    cpu_valid = 1'b0;
    checks++; if (control_op !== 8'd7) begin fails++; $display("FAIL vsync_waited_op: got %h want 07", control_op); end
    checks++; if (control_data !== 32'h77770007) begin fails++; $display("FAIL vsync_waited_data: got %h want 77770007", control_data); end
    for (int i = 0; i < 8; i++) tick();
    checks++; if (ops_issued !== 16'd4) begin fails++; $display("FAIL vsync_ops_final: got %0d want 4", ops_issued); end
  endtask

  task automatic test_arbitration();
    logic        is_cpu;
    int          k;
    logic [7:0]  exp_op;
    logic [7:0]  idx;
    logic [23:0] rgb;
    logic [31:0] exp_data;
    aresetn = 1'b0;
    tick();
    aresetn       = 1'b1;
    auto_vsync_en = 1'b0;
    cpu_op        = 8'd8;
    cpu_data      = 32'hC0DE0000;
    pal_index     = 8'h10;
    pal_rgb       = 24'hA0B0C0;
    cpu_valid     = 1'b1;
    pal_valid     = 1'b1;
    #1;
    for (int g = 0; g < 8; g++) begin
      is_cpu = ((g % 2) == 0);
      k      = g / 2;
      checks++; if ({cpu_ready, pal_ready} !== {is_cpu, ~is_cpu}) begin fails++; $display("FAIL arb_grant[%0d]: got %b want %b", g, {cpu_ready, pal_ready}, {is_cpu, ~is_cpu}); end
      tick();
      idx = 8'h10 + 8'(k);
      rgb = 24'hA0B0C0 + 24'(k);
      exp_op   = is_cpu ? 8'(8 + k) : 8'd3;
      exp_data = is_cpu ? (32'hC0DE0000 + 32'(k)) : {idx, rgb};
      checks++; if (control_op !== exp_op) begin fails++; $display("FAIL arb_op[%0d]: got %h want %h", g, control_op, exp_op); end
      checks++; if (control_data !== exp_data) begin fails++; $display("FAIL arb_data[%0d]: got %h want %h", g, control_data, exp_data); end
      if (is_cpu) begin
        if (k < 3) begin
          cpu_op   = 8'(9 + k);
          cpu_data = 32'hC0DE0000 + 32'(k + 1);
        end else begin
          cpu_valid = 1'b0;
        end
      end else begin
        if (k < 3) begin
          pal_index = 8'h10 + 8'(k + 1);
          pal_rgb   = 24'hA0B0C0 + 24'(k + 1);
        end else begin
          pal_valid = 1'b0;
        end
      end
      for (int j = 0; j < 8; j++) begin
        checks++; if ({cpu_ready, pal_ready} !== 2'b00) begin fails++; $display("FAIL arb_wait_ready[%0d.%0d]: got %b want 00", g, j, {cpu_ready, pal_ready}); end
        tick();
      end
    end
    checks++; if (ops_issued !== 16'd8) begin fails++; $display("FAIL arb_ops: got %0d want 8", ops_issued); end
  endtask

  task automatic test_palette_burst();
    logic [7:0] iv;
    aresetn = 1'b0;
    tick();
    aresetn   = 1'b1;
    pal_index = 8'h00;
    pal_rgb   = {8'h00, 8'hFF, 8'h5A};
    pal_valid = 1'b1;
    #1;
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      checks++; if (pal_ready !== 1'b1) begin fails++; $display("FAIL burst_ready[%0d]: got %b want 1", i, pal_ready); end
      tick();
      checks++; if (control_op !== 8'd3) begin fails++; $display("FAIL burst_op[%0d]: got %h want 03", i, control_op); end
      checks++; if (control_data !== {iv, iv, ~iv, 8'h5A}) begin fails++; $display("FAIL burst_data[%0d]: got %h want %h", i, control_data, {iv, iv, ~iv, 8'h5A}); end
      if (i < 255) begin
        pal_index = iv + 8'd1;
        pal_rgb   = {iv + 8'd1, ~(iv + 8'd1), 8'h5A};
      end else begin
        pal_valid = 1'b0;
      end
      #1;
      checks++; if (pal_ready !== 1'b0) begin fails++; $display("FAIL burst_hold_ready[%0d]: got %b want 0", i, pal_ready); end
      for (int j = 0; j < 8; j++) tick();
    end
    checks++; if (ops_issued !== 16'd256) begin fails++; $display("FAIL burst_ops: got %0d want 256", ops_issued); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL burst_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_op;
    cpu_op        = 8'd1;
    cpu_data      = 32'hDEAD0001;
    auto_vsync_en = 1'b0;
    cpu_valid     = 1'b1;
    #1;
    tick();
    checks++; if (control_op !== 8'd1) begin fails++; $display("FAIL rmid_first_op: got %h want 01", control_op); end
    tick();
    aresetn = 1'b0;
    tick();
    checks++; if (control_op !== 8'd0) begin fails++; $display("FAIL rmid_op: got %h want 00", control_op); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (ops_issued !== 16'd0) begin fails++; $display("FAIL rmid_ops: got %0d want 0", ops_issued); end
    checks++; if (cpu_ready !== 1'b0) begin fails++; $display("FAIL rmid_ready_in_reset: got %b want 0", cpu_ready); end
    aresetn = 1'b1;
    #1;
    checks++; if (cpu_ready !== 1'b1) begin fails++; $display("FAIL rmid_reaccept_ready: got %b want 1", cpu_ready); end
    tick();
    cpu_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_op = (i < 4) ? 8'd1 : 8'd0;
      checks++; if (control_op !== exp_op) begin fails++; $display("FAIL rmid_replay_op[%0d]: got %h want %h", i, control_op, exp_op); end
      tick();
    end
    checks++; if (ops_issued !== 16'd1) begin fails++; $display("FAIL rmid_ops_after: got %0d want 1", ops_issued); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_idle: got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    force dut.ops_issued = 16'hFFFF;
    #1;
    release dut.ops_issued;
    cpu_op    = 8'd6;
    cpu_data  = 32'h00000006;
    cpu_valid = 1'b1;
    #1;
    tick();
    cpu_valid = 1'b0;
    checks++; if (ops_issued !== 16'h0000) begin fails++; $display("FAIL wrap_ops: got %h want 0000", ops_issued); end
    checks++; if (control_op !== 8'd6) begin fails++; $display("FAIL wrap_op: got %h want 06", control_op); end
    for (int i = 0; i < 8; i++) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_vsync();
    test_arbitration();
    test_palette_burst();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
